// File: rtl/vic_regs.sv
// VIC-I register file: CPU-visible $9000-$900F plus frame-synced display decode.
// Optional raster compare interrupt at $9010/$9011 under VIC_RASTER_IRQ_EN.
module vic_regs #(
    parameter logic [15:0] COLOR_RAM_BASE = 16'h9400,
    parameter logic [7:0]  PADDLE_VALUE   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic [7:0]  raster_line,
    output logic [15:0] screen_addr,
    output logic [15:0] char_rom_addr,
    output logic [15:0] color_ram_addr,
    output logic [6:0]  xorigin,
    output logic [7:0]  yorigin,
    output logic [6:0]  cols,
    output logic [6:0]  rows,
    output logic        chars8x16,
    output logic [2:0]  border_color,
    output logic [3:0]  back_color,
    output logic [3:0]  aux_color,
    output logic        inverted,
    output logic [7:0]  osc1,
    output logic [7:0]  osc2,
    output logic [7:0]  osc3,
    output logic [7:0]  noise,
    output logic [3:0]  volume,
    output logic        irq
);

    logic [7:0]  pend [16];
    logic [7:0]  s0, s1, s2, s3, s5;
    logic [7:0]  rl_q;
    logic [7:0]  rdata;
    logic [3:0]  idx;
    logic [13:0] vscr, vchr;
    logic        wr, rd, wr_lo, frame_start;
    logic [1:0]  unused_bits;

    assign idx = addr[3:0];
    assign wr  = cs & we;
    assign rd  = cs & ~we;
    assign frame_start = (rl_q != 8'd0) && (raster_line == 8'd0);
    assign unused_bits = {s0[7], s3[7]};

`ifdef VIC_RASTER_IRQ_EN
    logic [7:0] cmp;
    logic       irq_en, irq_flag, hit, wr_ctrl;

    assign wr_lo   = wr & ~addr[4];
    assign wr_ctrl = wr && (addr == 5'h11);
    assign hit     = (raster_line != rl_q) && (raster_line == cmp);
    assign irq     = irq_flag & irq_en;

    // A compare hit on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp      <= 8'h00;
            irq_en   <= 1'b0;
            irq_flag <= 1'b0;
        end else begin
            if (wr && (addr == 5'h10))
                cmp <= din;
            if (wr_ctrl)
                irq_en <= din[1];
            if (hit)
                irq_flag <= 1'b1;
            else if (wr_ctrl && din[0])
                irq_flag <= 1'b0;
        end
    end
`else
    logic unused_addr4;

    assign unused_addr4 = addr[4];
    assign wr_lo = wr;
    assign irq   = 1'b0;
`endif

    always_comb begin
        rdata = pend[idx];
        case (idx)
            4'h3:       rdata = {1'b0, pend[3][6:0]};
            4'h4:       rdata = raster_line;
            4'h6, 4'h7: rdata = 8'h00;
            4'h8, 4'h9: rdata = PADDLE_VALUE;
            default:    rdata = pend[idx];
        endcase
`ifdef VIC_RASTER_IRQ_EN
        if (addr[4]) begin
            case (idx)
                4'h0:    rdata = cmp;
                4'h1:    rdata = {6'b0, irq_en, irq_flag};
                default: rdata = 8'h00;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++)
                pend[i] <= 8'h00;
            dout <= 8'h00;
            rl_q <= 8'h00;
        end else begin
            rl_q <= raster_line;
            if (wr_lo)
                pend[idx] <= din;
            if (rd)
                dout <= rdata;
        end
    end

    // Shadow samples pending before any same-edge write lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0 <= 8'h00;
            s1 <= 8'h00;
            s2 <= 8'h00;
            s3 <= 8'h00;
            s5 <= 8'h00;
        end else if (frame_start) begin
            s0 <= pend[0];
            s1 <= pend[1];
            s2 <= pend[2];
            s3 <= pend[3];
            s5 <= pend[5];
        end
    end

    assign vscr = {s5[7:4], s2[7], 9'b0};
    assign vchr = {s5[3:0], 10'b0};

    assign screen_addr    = {~vscr[13], 2'b00, vscr[12:0]};
    assign char_rom_addr  = {~vchr[13], 2'b00, vchr[12:0]};
    assign color_ram_addr = COLOR_RAM_BASE +
                            (s2[7] ? 16'h0200 : 16'h0000);

    assign xorigin   = s0[6:0];
    assign yorigin   = s1;
    assign cols      = s2[6:0];
    assign rows      = {1'b0, s3[6:1]};
    assign chars8x16 = s3[0];

    assign border_color = pend[15][2:0];
    assign inverted     = pend[15][3];
    assign back_color   = pend[15][7:4];
    assign aux_color    = pend[14][7:4];
    assign volume       = pend[14][3:0];
    assign osc1         = pend[10];
    assign osc2         = pend[11];
    assign osc3         = pend[12];
    assign noise        = pend[13];

endmodule

// File: tb/tb_vic_regs.sv
// Bench for vic_regs: directed vector table, hand sequences, then random
// traffic checked against a register-level model of the VIC-I map.
module tb_vic_regs;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [7:0]  din = '0;
    logic [7:0]  raster_line = '0;
    logic [7:0]  dout;
    logic [15:0] screen_addr, char_rom_addr, color_ram_addr;
    logic [6:0]  xorigin, cols, rows;
    logic [7:0]  yorigin, osc1, osc2, osc3, noise;
    logic        chars8x16, inverted, irq;
    logic [2:0]  border_color;
    logic [3:0]  back_color, aux_color, volume;

    vic_regs dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we),
        .addr(addr), .din(din), .dout(dout),
        .raster_line(raster_line),
        .screen_addr(screen_addr), .char_rom_addr(char_rom_addr),
        .color_ram_addr(color_ram_addr),
        .xorigin(xorigin), .yorigin(yorigin),
        .cols(cols), .rows(rows), .chars8x16(chars8x16),
        .border_color(border_color), .back_color(back_color),
        .aux_color(aux_color), .inverted(inverted),
        .osc1(osc1), .osc2(osc2), .osc3(osc3), .noise(noise),
        .volume(volume), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: register bytes plus the frame-latched display copy.
    logic [7:0] m_pend [16];
    logic [7:0] m_shad [6];
    logic [7:0] m_prev, m_dout, m_cmp;
    bit         m_en, m_flag;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 8'h00;
        for (int i = 0; i < 6; i++) m_shad[i] = 8'h00;
        m_prev = 0; m_dout = 0; m_cmp = 0; m_en = 0; m_flag = 0;
    endtask

    function automatic logic [7:0] model_read(logic [4:0] a, logic [7:0] r);
        int i;
`ifdef VIC_RASTER_IRQ_EN
        if (a == 5'h10) return m_cmp;
        if (a == 5'h11) return {6'b0, m_en, m_flag};
        if (a >= 5'h12) return 8'h00;
`endif
        i = int'(a) % 16;
        if (i == 3) return m_pend[3] % 128;
        if (i == 4) return r;
        if (i == 6 || i == 7) return 8'h00;
        if (i == 8 || i == 9) return 8'hFF;
        return m_pend[i];
    endfunction

    task automatic model_edge();
        logic [7:0] r;
        bit fs, hit;
        r = raster_line;
        fs = (m_prev != 0) && (r == 0);
        hit = (r != m_prev) && (r == m_cmp);
        if (cs && !we) m_dout = model_read(addr, r);
        if (fs) for (int i = 0; i < 6; i++) m_shad[i] = m_pend[i];
        if (cs && we) begin
`ifdef VIC_RASTER_IRQ_EN
            if (addr == 5'h10) m_cmp = din;
            else if (addr == 5'h11) begin
                m_en = din[1];
                if (din[0]) m_flag = 0;
            end else if (addr < 5'h10) m_pend[addr[3:0]] = din;
`else
            m_pend[int'(addr) % 16] = din;
`endif
        end
`ifdef VIC_RASTER_IRQ_EN
        if (hit) m_flag = 1;
`endif
        m_prev = r;
    endtask

    // VIC 14-bit address space: low half seen by the CPU at $8000, high half at $0000.
    function automatic logic [15:0] cpu_of(int v);
        return (v < 8192) ? 16'(v + 32'h8000) : 16'(v - 8192);
    endfunction

    task automatic check_all();
        int s2, s3, s5, p14, p15;
        s2 = m_shad[2]; s3 = m_shad[3]; s5 = m_shad[5];
        p14 = m_pend[14]; p15 = m_pend[15];
        chk("xorigin", 16'(xorigin), 16'(m_shad[0] % 128));
        chk("yorigin", 16'(yorigin), 16'(m_shad[1]));
        chk("cols", 16'(cols), 16'(s2 % 128));
        chk("rows", 16'(rows), 16'((s3 / 2) % 64));
        chk("chars8x16", 16'(chars8x16), 16'(s3 % 2));
        chk("screen_addr", screen_addr,
            cpu_of((s5 / 16) * 1024 + (s2 / 128) * 512));
        chk("char_rom_addr", char_rom_addr, cpu_of((s5 % 16) * 1024));
        chk("color_ram_addr", color_ram_addr,
            16'(32'h9400 + ((s2 >= 128) ? 512 : 0)));
        chk("border_color", 16'(border_color), 16'(p15 % 8));
        chk("inverted", 16'(inverted), 16'((p15 / 8) % 2));
        chk("back_color", 16'(back_color), 16'(p15 / 16));
        chk("aux_color", 16'(aux_color), 16'(p14 / 16));
        chk("volume", 16'(volume), 16'(p14 % 16));
        chk("osc1", 16'(osc1), 16'(m_pend[10]));
        chk("osc2", 16'(osc2), 16'(m_pend[11]));
        chk("osc3", 16'(osc3), 16'(m_pend[12]));
        chk("noise", 16'(noise), 16'(m_pend[13]));
        chk("dout", 16'(dout), 16'(m_dout));
        chk("irq", 16'(irq), 16'(m_en && m_flag));
    endtask

    task automatic cyc(bit c, bit w, logic [4:0] a, logic [7:0] d,
                       logic [7:0] r);
        cs = c; we = w; addr = a; din = d; raster_line = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_reset(string tag);
        chk({tag, " cols"}, 16'(cols), 16'h0);
        chk({tag, " rows"}, 16'(rows), 16'h0);
        chk({tag, " screen"}, screen_addr, 16'h8000);
        chk({tag, " char"}, char_rom_addr, 16'h8000);
        chk({tag, " color"}, color_ram_addr, 16'h9400);
        chk({tag, " irq"}, 16'(irq), 16'h0);
        chk({tag, " dout"}, 16'(dout), 16'h0);
    endtask

    typedef enum int {
        S_SCR, S_CHR, S_COL, S_COLS, S_ROWS, S_C816,
        S_BRD, S_INV, S_BACK, S_DOUT, S_XOR
    } sel_t;

    typedef struct {
        bit         c;
        bit         w;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] r;
        sel_t       sel;
        logic [15:0] exp;
        string      name;
    } vec_t;

    function automatic vec_t mk(bit c, bit w, logic [4:0] a, logic [7:0] d,
                                logic [7:0] r, sel_t sel,
                                logic [15:0] exp, string name);
        vec_t v;
        v.c = c; v.w = w; v.a = a; v.d = d; v.r = r;
        v.sel = sel; v.exp = exp; v.name = name;
        return v;
    endfunction

    function automatic logic [15:0] pick(sel_t sel);
        case (sel)
            S_SCR:  return screen_addr;
            S_CHR:  return char_rom_addr;
            S_COL:  return color_ram_addr;
            S_COLS: return 16'(cols);
            S_ROWS: return 16'(rows);
            S_C816: return 16'(chars8x16);
            S_BRD:  return 16'(border_color);
            S_INV:  return 16'(inverted);
            S_BACK: return 16'(back_color);
            S_DOUT: return 16'(dout);
            default: return 16'(xorigin);
        endcase
    endfunction

    vec_t tv [$];

    initial begin
        int r;
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h10, S_SCR, 16'h8000, "scr_idle"));
        tv.push_back(mk(1, 1, 5'h05, 8'hF0, 8'h11, S_SCR, 16'h8000, "scr_held"));
        tv.push_back(mk(1, 1, 5'h02, 8'h96, 8'h12, S_COLS, 16'd0, "cols_held"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h12, S_COL, 16'h9400, "color_held"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h00, S_SCR, 16'h1E00, "scr_frame"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h00, S_CHR, 16'h8000, "chr_frame"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h01, S_COLS, 16'd22, "cols_frame"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h01, S_COL, 16'h9600, "color_frame"));
        tv.push_back(mk(1, 1, 5'h0F, 8'h1B, 8'h02, S_ROWS, 16'd0, "wr_900f"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h02, S_BRD, 16'd3, "border"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h03, S_INV, 16'd1, "inverted"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h5A, S_BACK, 16'd1, "back"));
        tv.push_back(mk(1, 0, 5'h04, 8'h00, 8'h5A, S_DOUT, 16'h5A, "rd_raster"));
        tv.push_back(mk(1, 0, 5'h06, 8'h00, 8'h5A, S_DOUT, 16'h00, "rd_lpen"));
        tv.push_back(mk(1, 0, 5'h08, 8'h00, 8'h5A, S_DOUT, 16'hFF, "rd_paddle"));
        tv.push_back(mk(0, 0, 5'h04, 8'h00, 8'h5A, S_DOUT, 16'hFF, "dout_hold"));
        tv.push_back(mk(1, 1, 5'h03, 8'h2F, 8'h00, S_ROWS, 16'd0, "rows_fsedge"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h00, S_C816, 16'd0, "c816_fsedge"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h07, S_ROWS, 16'd0, "rows_wait"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h00, S_ROWS, 16'd23, "rows_next"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h00, S_C816, 16'd1, "c816_next"));
        tv.push_back(mk(1, 0, 5'h03, 8'h00, 8'h00, S_DOUT, 16'h2F, "rd_9003"));
        tv.push_back(mk(1, 1, 5'h00, 8'h55, 8'h00, S_XOR, 16'h0, "wr_xorg"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h00, S_XOR, 16'h0, "stuck0"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h01, S_XOR, 16'h0, "line1"));
        tv.push_back(mk(0, 0, 5'h00, 8'h00, 8'h00, S_XOR, 16'h55, "xorg_frame"));

        model_reset();
        #2;
        check_reset("reset");
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tv[i]) begin
            cyc(tv[i].c, tv[i].w, tv[i].a, tv[i].d, tv[i].r);
            chk(tv[i].name, pick(tv[i].sel), tv[i].exp);
        end

`ifdef VIC_RASTER_IRQ_EN
        cyc(1, 1, 5'h10, 8'h40, 8'h3E);
        cyc(1, 1, 5'h11, 8'h02, 8'h3E);
        cyc(0, 0, 5'h00, 8'h00, 8'h3F);
        chk("irq_before", 16'(irq), 16'h0);
        cyc(0, 0, 5'h00, 8'h00, 8'h40);
        chk("irq_hit", 16'(irq), 16'h1);
        cyc(0, 0, 5'h00, 8'h00, 8'h40);
        chk("irq_held", 16'(irq), 16'h1);
        cyc(1, 0, 5'h11, 8'h00, 8'h41);
        chk("rd_9011", 16'(dout), 16'h03);
        cyc(1, 1, 5'h11, 8'h03, 8'h41);
        chk("irq_clear", 16'(irq), 16'h0);
        cyc(0, 0, 5'h00, 8'h00, 8'h3F);
        cyc(1, 1, 5'h11, 8'h03, 8'h40);
        chk("irq_set_wins", 16'(irq), 16'h1);
`else
        cyc(1, 0, 5'h10, 8'h00, 8'h02);
        chk("alias_rd", 16'(dout), 16'h55);
        cyc(1, 1, 5'h12, 8'hAA, 8'h03);
        cyc(1, 0, 5'h02, 8'h00, 8'h04);
        chk("alias_wr", 16'(dout), 16'hAA);
        chk("irq_tied", 16'(irq), 16'h0);
`endif

        r = 5;
        for (int i = 0; i < 2000; i++) begin
            int k;
            k = int'($urandom_range(0, 99));
            if (i == 1000) begin
                cs = 0; we = 0;
                reset_n = 1'b0;
                #1;
                model_reset();
                check_reset("midreset");
                @(negedge clk);
                reset_n = 1'b1;
            end
            if (k < 3) r = 0;
            else if (k < 6) r = int'($urandom_range(0, 255));
            else if (k < 90) r = (r + 1) % 40;
            cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                5'($urandom), 8'($urandom), 8'(r));
            check_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
